// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection model: light codes, turn codes,
// approach indices and sensor bit positions, plus the light/turn permission rule.
package traffic_pkg;

  // Light codes driven by the controller; 5..7 are illegal and behave as Stop.
  localparam logic [2:0] LIGHT_STOP    = 3'd0;
  localparam logic [2:0] LIGHT_FORWARD = 3'd1;
  localparam logic [2:0] LIGHT_LEFT    = 3'd2;
  localparam logic [2:0] LIGHT_RIGHT   = 3'd3;
  localparam logic [2:0] LIGHT_GO      = 3'd4;

  typedef enum logic [1:0] {
    TURN_FORWARD = 2'd0,
    TURN_LEFT    = 2'd1,
    TURN_RIGHT   = 2'd2,
    TURN_INVALID = 2'd3
  } turn_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_CROSSING = 1'b1
  } approach_state_e;

  // Approach index order; opposite pairs differ only in bit 0 (N/S, E/W).
  localparam int APP_N = 0;
  localparam int APP_S = 1;
  localparam int APP_E = 2;
  localparam int APP_W = 3;
  localparam int NUM_APPROACHES = 4;

  // Positions inside sensor_light.
  localparam int CENTRE_S = 0;
  localparam int CENTRE_W = 1;
  localparam int CENTRE_E = 2;
  localparam int CENTRE_N = 3;
  localparam int WAIT_S   = 4;
  localparam int WAIT_E   = 5;
  localparam int WAIT_N   = 6;
  localparam int WAIT_W   = 7;

  function automatic logic light_permits(input logic [2:0] light, input turn_e turn);
    case (light)
      LIGHT_GO:      return 1'b1;
      LIGHT_FORWARD: return turn == TURN_FORWARD;
      LIGHT_LEFT:    return turn == TURN_LEFT;
      LIGHT_RIGHT:   return turn == TURN_RIGHT;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic is_illegal_light(input logic [2:0] light);
    return light > LIGHT_GO;
  endfunction

  function automatic logic is_opposite(input int a, input int b);
    return (a ^ b) == 1;
  endfunction

endpackage

// File: rtl/approach_queue.sv
// One approach of the intersection: a FIFO of waiting cars' turn codes and an
// IDLE/CROSSING state machine that releases the head car when its light permits.
module approach_queue
  import traffic_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CROSS_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] light,
  input  logic       arrive,
  input  logic [1:0] arrive_turn,
  output logic       waiting,
  output logic       crossing,
  output logic       full,
  output turn_e      turn,
  output logic       dropped,
  output logic       done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [3:0] TIMER_LOAD = 4'(CROSS_CYCLES - 1);

  turn_e           mem [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  approach_state_e state, state_next;
  logic [3:0]      timer, timer_next;
  turn_e           turn_next;
  turn_e           head;
  logic            empty, pop, push;

  assign head     = mem[rd_ptr];
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign waiting  = !empty;
  assign crossing = (state == ST_CROSSING);

  // A full queue still accepts an arrival when its head leaves on the same edge.
  assign push    = arrive && (arrive_turn != TURN_INVALID) && (!full || pop);
  assign dropped = arrive && !push;

  // Release decision and crossing countdown.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_next = state;
    timer_next = timer;
    turn_next  = turn;
    pop        = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty && light_permits(light, head)) begin
          pop        = 1'b1;
          turn_next  = head;
          timer_next = TIMER_LOAD;
          state_next = ST_CROSSING;
        end
      end
      ST_CROSSING: begin
        if (timer == 4'd0) begin
          state_next = ST_IDLE;
          done       = 1'b1;
        end else begin
          timer_next = timer - 4'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register for the crossing FSM.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only, so all registers see pre-edge values.
    if (!rst) begin
      state <= ST_IDLE;
      timer <= 4'd0;
      turn  <= TURN_FORWARD;
    end else begin
      state <= state_next;
      timer <= timer_next;
      turn  <= turn_next;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers and count define which entries are valid.
    if (push) mem[wr_ptr] <= turn_e'(arrive_turn);
  end

endmodule

// File: rtl/intersection_model.sv
// Four-way intersection: four approach queues, conflict detection between
// concurrent crossings, event counters and packing of the sensor vector.
module intersection_model
  import traffic_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int CROSS_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  outN,
  input  logic [2:0]  outS,
  input  logic [2:0]  outE,
  input  logic [2:0]  outW,
  input  logic [3:0]  arrive,
  input  logic [7:0]  arrive_turn,
  output logic [7:0]  sensor_light,
  output logic [29:0] general_sensors,
  output logic        collision,
  output logic        illegal_code,
  output logic [7:0]  drop_count,
  output logic [15:0] throughput,
  output logic [7:0]  collision_cycles
);

  logic [2:0] light [NUM_APPROACHES];
  logic [3:0] waiting, crossing, full, dropped, done;
  turn_e      turns [NUM_APPROACHES];

  assign light[APP_N] = outN;
  assign light[APP_S] = outS;
  assign light[APP_E] = outE;
  assign light[APP_W] = outW;

  for (genvar g = 0; g < NUM_APPROACHES; g++) begin : g_app
    approach_queue #(
      .DEPTH        (DEPTH),
      .CROSS_CYCLES (CROSS_CYCLES)
    ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .light       (light[g]),
      .arrive      (arrive[g]),
      .arrive_turn (arrive_turn[2*g +: 2]),
      .waiting     (waiting[g]),
      .crossing    (crossing[g]),
      .full        (full[g]),
      .turn        (turns[g]),
      .dropped     (dropped[g]),
      .done        (done[g])
    );
  end

  // Sensor packing straight from registered queue/FSM state.
  always_comb begin
    sensor_light           = '0;
    sensor_light[WAIT_S]   = waiting[APP_S];
    sensor_light[WAIT_E]   = waiting[APP_E];
    sensor_light[WAIT_N]   = waiting[APP_N];
    sensor_light[WAIT_W]   = waiting[APP_W];
    sensor_light[CENTRE_S] = crossing[APP_S];
    sensor_light[CENTRE_W] = crossing[APP_W];
    sensor_light[CENTRE_E] = crossing[APP_E];
    sensor_light[CENTRE_N] = crossing[APP_N];
  end

  assign general_sensors = {26'd0, full};

  logic        conflict, illegal_now;
  logic [2:0]  drop_inc, done_inc;
  logic [8:0]  drop_sum;
  logic [16:0] thr_sum;

  // Pairwise conflict check over crossings; right turns and opposing forwards are safe.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NUM_APPROACHES; i++) begin
      for (int j = i + 1; j < NUM_APPROACHES; j++) begin
        if (crossing[i] && crossing[j] &&
            !(turns[i] == TURN_RIGHT || turns[j] == TURN_RIGHT) &&
            !(is_opposite(i, j) && turns[i] == TURN_FORWARD && turns[j] == TURN_FORWARD))
          conflict = 1'b1;
      end
    end
  end

  // Per-cycle event totals feeding the saturating counters.
  always_comb begin
    drop_inc    = '0;
    done_inc    = '0;
    illegal_now = 1'b0;
    for (int i = 0; i < NUM_APPROACHES; i++) begin
      drop_inc    = drop_inc + {2'b00, dropped[i]};
      done_inc    = done_inc + {2'b00, done[i]};
      illegal_now = illegal_now | is_illegal_light(light[i]);
    end
    drop_sum = {1'b0, drop_count} + {6'd0, drop_inc};
    thr_sum  = {1'b0, throughput} + {14'd0, done_inc};
  end

  // Sticky flags and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      collision        <= 1'b0;
      illegal_code     <= 1'b0;
      drop_count       <= '0;
      throughput       <= '0;
      collision_cycles <= '0;
    end else begin
      if (conflict)    collision    <= 1'b1;
      if (illegal_now) illegal_code <= 1'b1;
      drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      throughput <= thr_sum[16] ? 16'hFFFF : thr_sum[15:0];
      if (conflict && collision_cycles != 8'hFF)
        collision_cycles <= collision_cycles + 8'd1;
    end
  end

endmodule

// File: tb/tb_intersection_model.sv
// Directed bench for intersection_model. Stimulus pushes expected releases and
// expected output values (tagged with the edge count they belong to) into queues;
// a monitor on the falling edge pops and compares them.
module tb_intersection_model;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  out_n, out_s, out_e, out_w;
  logic [3:0]  arrive;
  logic [7:0]  arrive_turn;
  logic [7:0]  sensor_light;
  logic [29:0] general_sensors;
  logic        collision, illegal_code;
  logic [7:0]  drop_count, collision_cycles;
  logic [15:0] throughput;

  intersection_model #(.DEPTH(4), .CROSS_CYCLES(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .outN             (out_n),
    .outS             (out_s),
    .outE             (out_e),
    .outW             (out_w),
    .arrive           (arrive),
    .arrive_turn      (arrive_turn),
    .sensor_light     (sensor_light),
    .general_sensors  (general_sensors),
    .collision        (collision),
    .illegal_code     (illegal_code),
    .drop_count       (drop_count),
    .throughput       (throughput),
    .collision_cycles (collision_cycles)
  );

  always #5 clk = ~clk;

  typedef enum {F_SENSOR, F_GENERAL, F_COLL, F_ILLEGAL, F_DROP, F_THR, F_CCYC} field_e;
  typedef struct { int cyc; field_e f; logic [31:0] val; string name; } chk_t;
  typedef struct { int cyc; int bitn; } rel_t;

  chk_t chk_q [$];
  rel_t rel_q [$];
  int   edge_cnt = 0;
  int   total = 0;
  int   bad = 0;
  logic [3:0] prev_centre = '0;

  always @(posedge clk) edge_cnt = edge_cnt + 1;

  function automatic logic [31:0] read_field(input field_e f);
    case (f)
      F_SENSOR:  return {24'd0, sensor_light};
      F_GENERAL: return {2'd0, general_sensors};
      F_COLL:    return {31'd0, collision};
      F_ILLEGAL: return {31'd0, illegal_code};
      F_DROP:    return {24'd0, drop_count};
      F_THR:     return {16'd0, throughput};
      default:   return {24'd0, collision_cycles};
    endcase
  endfunction

  // Monitor: value checks due this cycle, plus every rising centre bit matched to an expected release.
  always @(negedge clk) begin
    for (int i = chk_q.size() - 1; i >= 0; i--) begin
      if (chk_q[i].cyc == edge_cnt) begin
        total++;
        if (read_field(chk_q[i].f) !== chk_q[i].val) begin
          bad++;
          $display("FAIL %s @edge %0d: got 0x%0h want 0x%0h", chk_q[i].name, edge_cnt,
                   read_field(chk_q[i].f), chk_q[i].val);
        end
        chk_q.delete(i);
      end
    end
    for (int b = 0; b < 4; b++) begin
      if (sensor_light[b] && !prev_centre[b]) begin
        int hit;
        hit = -1;
        for (int k = 0; k < rel_q.size(); k++)
          if (rel_q[k].bitn == b && rel_q[k].cyc == edge_cnt) hit = k;
        total++;
        if (hit < 0) begin
          bad++;
          $display("FAIL release centre bit %0d @edge %0d: got release want none", b, edge_cnt);
        end else begin
          rel_q.delete(hit);
        end
      end
    end
    prev_centre = sensor_light[3:0];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input int d, input field_e f, input logic [31:0] v, input string name);
    chk_t c;
    c.cyc = edge_cnt + d; c.f = f; c.val = v; c.name = name;
    chk_q.push_back(c);
  endtask

  task automatic expect_rel(input int d, input int bitn);
    rel_t r;
    r.cyc = edge_cnt + d; r.bitn = bitn;
    rel_q.push_back(r);
  endtask

  initial begin
    // Reset held two cycles with arrivals and Go lights active.
    rst = 1'b0; arrive = 4'hF; arrive_turn = 8'h00;
    out_n = 3'd4; out_s = 3'd4; out_e = 3'd4; out_w = 3'd4;
    tick(2);
    expect_val(0, F_SENSOR, 0, "reset sensor");
    expect_val(0, F_GENERAL, 0, "reset general");
    expect_val(0, F_DROP, 0, "reset drop");
    expect_val(0, F_THR, 0, "reset thr");
    expect_val(0, F_COLL, 0, "reset coll");
    expect_val(0, F_ILLEGAL, 0, "reset illegal");
    expect_val(0, F_CCYC, 0, "reset ccyc");
    rst = 1'b1; arrive = 4'h0;
    out_n = 3'd0; out_s = 3'd0; out_e = 3'd0; out_w = 3'd0;
    expect_val(1, F_SENSOR, 0, "post-reset empty");
    tick(2);

    // Single northbound forward car under Forward_only.
    arrive = 4'b0001; arrive_turn = 8'h00; out_n = 3'd1;
    expect_val(1, F_SENSOR, 32'h40, "single wait");
    expect_rel(2, 3);
    expect_val(2, F_SENSOR, 32'h08, "single centre");
    expect_val(4, F_SENSOR, 32'h08, "single centre last");
    expect_val(4, F_THR, 0, "single thr before");
    expect_val(5, F_SENSOR, 0, "single done");
    expect_val(5, F_THR, 1, "single thr");
    tick(1); arrive = 4'h0;
    tick(6); out_n = 3'd0;

    // Southbound left car held by Forward_only, released by Left_only.
    arrive = 4'b0010; arrive_turn = 8'b00_00_01_00; out_s = 3'd1;
    expect_val(1, F_SENSOR, 32'h10, "wrong light wait");
    tick(1); arrive = 4'h0; arrive_turn = 8'h00;
    tick(4);
    expect_val(0, F_SENSOR, 32'h10, "wrong light held");
    out_s = 3'd2;
    expect_rel(1, 0);
    expect_val(1, F_SENSOR, 32'h01, "left centre");
    expect_val(3, F_THR, 1, "left thr before");
    expect_val(4, F_SENSOR, 0, "left done");
    expect_val(4, F_THR, 2, "left thr");
    tick(5); out_s = 3'd0;

    // Overflow: five northbound arrivals under Stop into a depth-4 queue.
    arrive = 4'b0001;
    expect_val(3, F_GENERAL, 0, "not yet full");
    expect_val(4, F_GENERAL, 1, "full flag");
    expect_val(4, F_DROP, 0, "no drop yet");
    expect_val(4, F_SENSOR, 32'h40, "full wait");
    expect_val(5, F_DROP, 1, "overflow drop");
    tick(5);
    // Full queue pops while a new car arrives: accepted, then five releases drain it.
    out_n = 3'd1;
    expect_val(1, F_DROP, 1, "full+pop no drop");
    expect_val(1, F_GENERAL, 1, "full+pop still full");
    expect_val(1, F_SENSOR, 32'h48, "full+pop sensor");
    expect_val(5, F_GENERAL, 0, "drain not full");
    for (int k = 0; k < 5; k++) expect_rel(1 + 4 * k, 3);
    expect_val(17, F_SENSOR, 32'h08, "last car centre");
    expect_val(19, F_THR, 6, "drain thr before");
    expect_val(20, F_THR, 7, "drain thr");
    expect_val(20, F_SENSOR, 0, "drained");
    tick(1); arrive = 4'h0;
    tick(21); out_n = 3'd0;

    // Two invalid-turn arrivals in one cycle add two drops.
    arrive = 4'b1010; arrive_turn = 8'b11_00_11_00;
    expect_val(1, F_DROP, 3, "double drop");
    expect_val(1, F_SENSOR, 0, "invalid not queued");
    tick(1); arrive = 4'h0; arrive_turn = 8'h00;
    tick(1);

    // North and east forward under Go together: conflict for three cycles.
    arrive = 4'b0101;
    tick(1); arrive = 4'h0;
    expect_val(0, F_SENSOR, 32'h60, "N+E waiting");
    out_n = 3'd4; out_e = 3'd4;
    expect_rel(1, 3);
    expect_rel(1, 2);
    expect_val(1, F_SENSOR, 32'h0C, "N+E centre");
    expect_val(1, F_COLL, 0, "coll before");
    expect_val(2, F_COLL, 1, "coll set");
    expect_val(2, F_CCYC, 1, "ccyc 1");
    expect_val(4, F_CCYC, 3, "ccyc 3");
    expect_val(5, F_CCYC, 3, "ccyc hold");
    expect_val(4, F_THR, 9, "N+E thr");
    tick(1); out_n = 3'd0; out_e = 3'd0;
    tick(5);

    // North and south forward: opposite forwards do not conflict.
    arrive = 4'b0011;
    tick(1); arrive = 4'h0;
    expect_val(0, F_SENSOR, 32'h50, "N+S waiting");
    out_n = 3'd4; out_s = 3'd4;
    expect_rel(1, 3);
    expect_rel(1, 0);
    expect_val(1, F_SENSOR, 32'h09, "N+S centre");
    expect_val(3, F_CCYC, 3, "N+S no ccyc");
    expect_val(5, F_CCYC, 3, "N+S no ccyc end");
    expect_val(5, F_COLL, 1, "coll sticky");
    expect_val(4, F_THR, 11, "N+S thr");
    tick(1); out_n = 3'd0; out_s = 3'd0;
    tick(5);

    // Illegal code on the west light: acts as Stop and sets the sticky flag.
    arrive = 4'b1000; out_w = 3'd6;
    expect_val(0, F_ILLEGAL, 0, "illegal before");
    expect_val(1, F_ILLEGAL, 1, "illegal set");
    expect_val(1, F_SENSOR, 32'h80, "illegal wait");
    tick(1); arrive = 4'h0;
    tick(3); out_w = 3'd0;
    tick(2);
    expect_val(0, F_ILLEGAL, 1, "illegal sticky");
    expect_val(0, F_SENSOR, 32'h80, "illegal held");
    tick(2);

    foreach (rel_q[k]) begin
      total++; bad++;
      $display("FAIL release centre bit %0d: got none want release @edge %0d", rel_q[k].bitn, rel_q[k].cyc);
    end
    foreach (chk_q[k]) begin
      total++; bad++;
      $display("FAIL %s: got unchecked want check @edge %0d", chk_q[k].name, chk_q[k].cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
